// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcodes and FSM state type shared by seq_alu and seq_alu_comb.
//               SEQ_ALU_MUL_EN adds the MUL state to the state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SBC  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SLL2 = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/seq_alu_comb.sv
// ============================================================================
// Module      : seq_alu_comb
// Description : Combinational single-cycle ALU ops and their status flags.
//               Opcode 1001 is reported illegal here; seq_alu overrides it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int c_SH_W = $clog2(WIDTH);
    localparam int c_MSB  = WIDTH - 1;

    logic [c_SH_W-1:0] w_amt;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c_in;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_shl;

    assign w_amt = b[c_SH_W-1:0];

    // Subtract forms share the adder by inverting B; only 0111 forces carry-in.
    always_comb begin
        w_b_eff = (sel == OP_ADD) ? b : ~b;
        w_c_in  = (sel == OP_SUB) ? 1'b1 : cin;
        w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_c_in};
        w_shl   = {1'b0, a} << w_amt;
    end

    always_comb begin
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_ADD, OP_SUB, OP_SBC: begin
                y        = w_sum[WIDTH-1:0];
                cout     = w_sum[WIDTH];
                overflow = (a[c_MSB] == w_b_eff[c_MSB]) && (y[c_MSB] != a[c_MSB]);
            end
            // The extra top bit of the widened shift is the last bit shifted out.
            OP_SLL, OP_SLL2: begin
                y        = w_shl[WIDTH-1:0];
                cout     = w_shl[WIDTH];
                overflow = y[c_MSB] ^ a[c_MSB];
            end
            OP_SRL:  y = a >> w_amt;
            OP_SRA:  y = $unsigned($signed(a) >>> w_amt);
            default: illegal = 1'b1;
        endcase
        negative = y[c_MSB];
        zero     = (y == '0) && !illegal;
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Handshaked sequential ALU: FSM, result registers and an
//               optional shift-add multiplier enabled by SEQ_ALU_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Negative,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_load_comb;
    logic [WIDTH-1:0] w_y;
    logic             w_cout;
    logic             w_neg;
    logic             w_zero;
    logic             w_ovf;
    logic             w_ill;
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic             r_neg;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;

    seq_alu_comb #(
        .WIDTH    (WIDTH)
    ) u_comb (
        .a        (A),
        .b        (B),
        .sel      (sel),
        .cin      (Cin),
        .y        (w_y),
        .cout     (w_cout),
        .negative (w_neg),
        .zero     (w_zero),
        .overflow (w_ovf),
        .illegal  (w_ill)
    );

    assign w_accept = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic               w_is_mul;
    logic               w_mul_last;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [c_CNT_W-1:0] r_cnt;

    assign w_is_mul    = (sel == OP_MUL);
    assign w_load_comb = w_accept && !w_is_mul;
    // One extra MUL cycle after the last iteration moves the product into Y.
    assign w_mul_last  = (r_state == ST_MUL) && (r_cnt == c_CNT_W'(WIDTH));
    assign w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // Product register starts as {0, B}; each step adds A on the low bit and shifts right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= A;
            r_prod  <= {{WIDTH{1'b0}}, B};
            r_cnt   <= '0;
        end else if ((r_state == ST_MUL) && !w_mul_last) begin
            r_prod  <= {w_add, r_prod[WIDTH-1:1]};
            r_cnt   <= r_cnt + c_CNT_W'(1);
        end
    end
`else
    assign w_load_comb = w_accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef SEQ_ALU_MUL_EN
                    w_next = w_is_mul ? ST_MUL : ST_DONE;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: begin
                if (w_mul_last) w_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Result registers only load on accept or multiply completion, so DONE holds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= '0;
            r_cout <= 1'b0;
            r_neg  <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_ill  <= 1'b0;
        end else if (w_load_comb) begin
            r_y    <= w_y;
            r_cout <= w_cout;
            r_neg  <= w_neg;
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
            r_ill  <= w_ill;
        end
`ifdef SEQ_ALU_MUL_EN
        else if (w_mul_last) begin
            r_y    <= r_prod[WIDTH-1:0];
            r_cout <= |r_prod[2*WIDTH-1:WIDTH];
            r_neg  <= r_prod[WIDTH-1];
            r_zero <= (r_prod[WIDTH-1:0] == '0);
            r_ovf  <= |r_prod[2*WIDTH-1:WIDTH];
            r_ill  <= 1'b0;
        end
`endif
    end

    assign Y        = r_y;
    assign Cout     = r_cout;
    assign Negative = r_neg;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;
    assign Illegal  = r_ill;

endmodule

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 A, B  input  WIDTH each  operands.
REQ-007 sel  input  4  operation code.
REQ-008 Cin  input  1  carry-in for add/subtract-with-carry.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 Y  output  WIDTH  result.
REQ-012 Cout, Negative, Zero, Overflow, Illegal  output  1 each  status flags.

Function
REQ-013 Operation is accepted when in_valid && in_ready; A, B, sel and Cin are captured on that edge, and later input changes do not affect the operation.
REQ-014 Ops: 0000 AND, 0001 OR, 0010 NOT A, 0011 NOR, 0100 XOR, 0101 NAND, all bitwise over full WIDTH; 0110 A+B+Cin; 0111 A-B (A+~B+1); 1000 A+~B+Cin; 1001 unsigned multiply; 1010/1011 left shift; 1100 logical right shift; 1101 arithmetic right shift.
REQ-015 Shift amount = B[$clog2(WIDTH)-1:0]; amounts >= WIDTH are not reachable.
REQ-016 Flags for bitwise ops: Cout=0, Overflow=0, Negative=Y[WIDTH-1], Zero=(Y==0).
REQ-017 Flags for 0110/0111/1000: Cout = carry out of the WIDTH-bit sum; Overflow = operands (A and the effective B) have the same sign and Y's sign differs; Negative=Y[WIDTH-1]; Zero=(Y==0).
REQ-018 Flags for left shifts: Cout = last bit shifted out (0 when amount=0); Overflow = Y[WIDTH-1]^A[WIDTH-1]. Flags for right shifts: Cout=0, Overflow=0. For all shifts, Negative=Y[WIDTH-1] and Zero=(Y==0).
REQ-019 Multiply: Y = low WIDTH bits of A*B; Cout=1 if the upper WIDTH bits are nonzero; Overflow=Cout; Negative=Y[WIDTH-1]; Zero=(Y==0).
REQ-020 sel 1110/1111 are illegal: Y=0, Illegal=1, all other flags 0, latency as a single-cycle op. Illegal=0 for every legal op.
REQ-021 FSM states: IDLE, MUL, DONE. Transitions:
- IDLE to DONE on accepting a non-multiply op.
- IDLE to MUL on accepting 1001.
- MUL to DONE after WIDTH iterations, one shift-add iteration per cycle.
- DONE to IDLE on out_ready.
REQ-022 in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-023 Latency from acceptance to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply.
REQ-024 In DONE with out_ready=0, Y and all flags hold stable indefinitely.
REQ-025 There is no same-cycle accept on the handshake edge: the earliest next accept is the cycle after DONE exits.

Reset
REQ-026 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, Y=0, all flags 0, multiply accumulator and counter cleared.
REQ-027 Reset asserted mid-multiply or in DONE aborts the operation; no result is delivered after reset release.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN is defined: 1001 is a legal multiply, MUL state and datapath are present.
REQ-029 Macro SEQ_ALU_MUL_EN is undefined: no MUL state or multiplier logic; 1001 is treated as illegal per REQ-020.

Structure
REQ-030 Shared package seq_alu_pkg holds the opcode localparams (OP_AND..OP_SRA, OP_MUL) and the FSM state typedef.
REQ-031 One sub-module, seq_alu_comb, implements the combinational single-cycle ops and their flags; seq_alu holds the FSM, capture registers and the iterative multiplier.

Verification (WIDTH=8)
REQ-032 Add: A=0x7F, B=0x01, Cin=0, sel=0110 -> Y=0x80, Overflow=1, Negative=1, Cout=0, out_valid 1 cycle after accept.
REQ-033 Subtract: A=0x05, B=0x05, sel=0111 -> Y=0x00, Zero=1, Cout=1, Overflow=0.
REQ-034 Multiply with SEQ_ALU_MUL_EN: A=0x10, B=0x11 -> Y=0x10, Cout=1, out_valid 9 cycles after accept, in_ready=0 throughout. Without the macro, the same stimulus -> Illegal=1, Y=0 after 1 cycle.
REQ-035 Backpressure: A=0x81, B=0x01, sel=1010 with out_ready=0 for 5 cycles -> Y=0x02, Cout=1, Overflow=1, held stable; in_ready stays 0 until the cycle after out_ready=1.
REQ-036 rst_n pulsed low 3 cycles into a multiply -> out_valid=0, in_ready=1 immediately, and no stale result appears afterwards.
REQ-037 sel=1101, A=0x80, B=0x03 -> Y=0xF0, Negative=1; sel=1111 -> Illegal=1.
